// File: rtl/render_pkg.sv
// rtl/render_pkg.sv - shared constants, bit indices and FSM state type for render_cfg_regs
package render_pkg;

  // Register byte addresses
  localparam logic [15:0] ADDR_FB_BASE   = 16'h0000;
  localparam logic [15:0] ADDR_VB_BASE   = 16'h0004;
  localparam logic [15:0] ADDR_CTRL      = 16'h0008;
  localparam logic [15:0] ADDR_STATUS    = 16'h000C;
  localparam logic [15:0] ADDR_MAT_BASE  = 16'h0100;
  localparam logic [15:0] ADDR_LIGHT_BASE = 16'h0800;

  // Matrix m lives in 256-byte page (ADDR_MAT_BASE>>8)+m, words 0..15 at the bottom
  localparam logic [7:0] MAT_PAGE_FIRST = ADDR_MAT_BASE[15:8];
  // Lighting words sit in the 64-byte block starting at ADDR_LIGHT_BASE
  localparam logic [9:0] LIGHT_BLOCK    = ADDR_LIGHT_BASE[15:6];

  // CTRL bit indices
  localparam int CTRL_START_BIT  = 0;
  localparam int CTRL_IRQ_EN_BIT = 1;

  // STATUS bit indices
  localparam int STATUS_BUSY_BIT    = 0;
  localparam int STATUS_DONE_BIT    = 1;
  localparam int STATUS_OVERRUN_BIT = 2;

  // Vertex buffer base comes out of reset pointing at this address
  localparam logic [25:0] VB_BASE_RESET = 26'h300000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_COMMIT = 2'd1,
    ST_BUSY   = 2'd2
  } render_state_t;

endpackage

// File: rtl/cfg_shadow_reg.sv
// rtl/cfg_shadow_reg.sv - byte-enabled shadow register with committed active copy
module cfg_shadow_reg #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [3:0]       byteenable,
  input  logic [WIDTH-1:0] writedata,
  input  logic             commit,
  output logic [WIDTH-1:0] shadow,
  output logic [WIDTH-1:0] active
);

  // Shadow copy: software writes land here lane by lane
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      shadow <= RESET_VAL;
    end else if (wr_en) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (byteenable[i / 8]) shadow[i] <= writedata[i];
      end
    end
  end

  // Active copy: only follows the shadow on a commit strobe
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      active <= RESET_VAL;
    end else if (commit) begin
      active <= shadow;
    end
  end

endmodule

// File: rtl/render_cfg_regs.sv
// rtl/render_cfg_regs.sv - renderer configuration registers with shadow/commit and start/done handshake
module render_cfg_regs
  import render_pkg::*;
#(
  parameter int NUM_MAT     = 2,
  parameter int LIGHT_WORDS = 3
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [15:0]              address,
  input  logic                     write,
  input  logic                     read,
  input  logic [31:0]              writedata,
  input  logic [3:0]               byteenable,
  output logic [31:0]              readdata,
  output logic                     readdatavalid,
  output logic [NUM_MAT*512-1:0]   mat_out,
  output logic [LIGHT_WORDS*32-1:0] lighting,
  output logic [25:0]              frame_buffer_base,
  output logic [25:0]              vertex_buffer_base,
  output logic                     render_start,
  input  logic                     render_done,
  output logic                     irq
);

  render_state_t state_q;
  logic          irq_en_q;
  logic          done_q;
  logic          overrun_q;

  logic [13:0] word_addr;
  logic        wr_strobe;
  logic        rd_strobe;
  logic        hit_fb, hit_vb, hit_ctrl, hit_status, hit_mat, hit_light;
  logic [5:0]  mat_index;
  logic [3:0]  light_index;
  logic        commit;
  logic        ctrl_wr, status_wr, start_req;
  logic        done_set, overrun_set;
  logic [31:0] rd_value;
  logic        unused_addr_bits;

  logic [31:0] mat_shadow   [64];
  logic [31:0] light_shadow [16];
  logic [25:0] fb_shadow;
  logic [25:0] vb_shadow;

  assign word_addr        = address[15:2];
  assign unused_addr_bits = ^address[1:0];
  // A simultaneous read and write is a write only
  assign wr_strobe        = write;
  assign rd_strobe        = read & ~write;

  // Address decode for the register page, matrix pages and lighting block
  always_comb begin
    hit_fb      = (word_addr == ADDR_FB_BASE[15:2]);
    hit_vb      = (word_addr == ADDR_VB_BASE[15:2]);
    hit_ctrl    = (word_addr == ADDR_CTRL[15:2]);
    hit_status  = (word_addr == ADDR_STATUS[15:2]);
    hit_mat     = (address[15:8] >= MAT_PAGE_FIRST) &&
                  (address[15:8] <  (MAT_PAGE_FIRST + 8'(NUM_MAT))) &&
                  (address[7:6] == 2'b00);
    mat_index   = {address[9:8] - 2'd1, address[5:2]};
    hit_light   = (address[15:6] == LIGHT_BLOCK) &&
                  ({1'b0, address[5:2]} < 5'(LIGHT_WORDS));
    light_index = address[5:2];
  end

  assign commit      = (state_q == ST_COMMIT);
  assign ctrl_wr     = wr_strobe & hit_ctrl & byteenable[0];
  assign status_wr   = wr_strobe & hit_status & byteenable[0];
  assign start_req   = ctrl_wr & writedata[CTRL_START_BIT];
  assign done_set    = (state_q == ST_BUSY) & render_done;
  assign overrun_set = start_req & (state_q != ST_IDLE);

  // Matrix words: one shadow/active pair per implemented word, spare read slots tie to 0
  for (genvar j = 0; j < 64; j++) begin : g_mat
    if (j < NUM_MAT * 16) begin : g_word
      cfg_shadow_reg #(
        .WIDTH     (32),
        .RESET_VAL (32'h0)
      ) u_reg (
        .clk        (clk),
        .reset_n    (reset_n),
        .wr_en      (wr_strobe & hit_mat & (mat_index == 6'(j))),
        .byteenable (byteenable),
        .writedata  (writedata),
        .commit     (commit),
        .shadow     (mat_shadow[j]),
        .active     (mat_out[j*32 +: 32])
      );
    end else begin : g_none
      assign mat_shadow[j] = '0;
    end
  end

  // Lighting words: same structure as matrices
  for (genvar k = 0; k < 16; k++) begin : g_light
    if (k < LIGHT_WORDS) begin : g_word
      cfg_shadow_reg #(
        .WIDTH     (32),
        .RESET_VAL (32'h0)
      ) u_reg (
        .clk        (clk),
        .reset_n    (reset_n),
        .wr_en      (wr_strobe & hit_light & (light_index == 4'(k))),
        .byteenable (byteenable),
        .writedata  (writedata),
        .commit     (commit),
        .shadow     (light_shadow[k]),
        .active     (lighting[k*32 +: 32])
      );
    end else begin : g_none
      assign light_shadow[k] = '0;
    end
  end

  cfg_shadow_reg #(
    .WIDTH     (26),
    .RESET_VAL (26'h0)
  ) u_fb_base (
    .clk        (clk),
    .reset_n    (reset_n),
    .wr_en      (wr_strobe & hit_fb),
    .byteenable (byteenable),
    .writedata  (writedata[25:0]),
    .commit     (commit),
    .shadow     (fb_shadow),
    .active     (frame_buffer_base)
  );

  cfg_shadow_reg #(
    .WIDTH     (26),
    .RESET_VAL (VB_BASE_RESET)
  ) u_vb_base (
    .clk        (clk),
    .reset_n    (reset_n),
    .wr_en      (wr_strobe & hit_vb),
    .byteenable (byteenable),
    .writedata  (writedata[25:0]),
    .commit     (commit),
    .shadow     (vb_shadow),
    .active     (vertex_buffer_base)
  );

  // Sequencer: IDLE -> COMMIT on START, COMMIT -> BUSY with a one-cycle start pulse, BUSY -> IDLE on done
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      render_start <= 1'b0;
    end else begin
      render_start <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_req) state_q <= ST_COMMIT;
        end
        ST_COMMIT: begin
          state_q      <= ST_BUSY;
          render_start <= 1'b1;
        end
        ST_BUSY: begin
          if (render_done) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Control and sticky status bits; a set in the same cycle as a clear wins
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      irq_en_q  <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      irq       <= 1'b0;
    end else begin
      if (ctrl_wr) irq_en_q <= writedata[CTRL_IRQ_EN_BIT];
      done_q    <= (done_q & ~(status_wr & writedata[STATUS_DONE_BIT])) | done_set;
      overrun_q <= (overrun_q & ~(status_wr & writedata[STATUS_OVERRUN_BIT])) | overrun_set;
      irq       <= done_q & irq_en_q;
    end
  end

  // Read mux over the pre-write register values
  always_comb begin
    rd_value = '0;
    if (hit_fb) begin
      rd_value = {6'b0, fb_shadow};
    end else if (hit_vb) begin
      rd_value = {6'b0, vb_shadow};
    end else if (hit_ctrl) begin
      rd_value[CTRL_IRQ_EN_BIT] = irq_en_q;
    end else if (hit_status) begin
      rd_value[STATUS_BUSY_BIT]    = (state_q != ST_IDLE);
      rd_value[STATUS_DONE_BIT]    = done_q;
      rd_value[STATUS_OVERRUN_BIT] = overrun_q;
    end else if (hit_mat) begin
      rd_value = mat_shadow[mat_index];
    end else if (hit_light) begin
      rd_value = light_shadow[light_index];
    end
  end

  // Read response registered one cycle after the read strobe
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      readdata      <= '0;
      readdatavalid <= 1'b0;
    end else begin
      readdatavalid <= rd_strobe;
      readdata      <= rd_strobe ? rd_value : 32'h0;
    end
  end

endmodule

// File: tb/tb_render_cfg_regs.sv
// tb/tb_render_cfg_regs.sv - directed table-driven bench for render_cfg_regs
module tb_render_cfg_regs;

  localparam int NUM_MAT     = 2;
  localparam int LIGHT_WORDS = 3;

  logic                      clk;
  logic                      reset_n;
  logic [15:0]               address;
  logic                      write;
  logic                      read;
  logic [31:0]               writedata;
  logic [3:0]                byteenable;
  logic [31:0]               readdata;
  logic                      readdatavalid;
  logic [NUM_MAT*512-1:0]    mat_out;
  logic [LIGHT_WORDS*32-1:0] lighting;
  logic [25:0]               frame_buffer_base;
  logic [25:0]               vertex_buffer_base;
  logic                      render_start;
  logic                      render_done;
  logic                      irq;

  int checks   = 0;
  int failures = 0;

  render_cfg_regs #(
    .NUM_MAT     (NUM_MAT),
    .LIGHT_WORDS (LIGHT_WORDS)
  ) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .address            (address),
    .write              (write),
    .read               (read),
    .writedata          (writedata),
    .byteenable         (byteenable),
    .readdata           (readdata),
    .readdatavalid      (readdatavalid),
    .mat_out            (mat_out),
    .lighting           (lighting),
    .frame_buffer_base  (frame_buffer_base),
    .vertex_buffer_base (vertex_buffer_base),
    .render_start       (render_start),
    .render_done        (render_done),
    .irq                (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        do_wr;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    address    = a;
    writedata  = d;
    byteenable = be;
    write      = 1'b1;
    @(negedge clk);
    write      = 1'b0;
    byteenable = 4'h0;
  endtask

  task automatic bus_read(input logic [15:0] a, input logic [31:0] exp, input string nm);
    @(negedge clk);
    address = a;
    read    = 1'b1;
    @(negedge clk);
    read = 1'b0;
    check({nm, "_valid"}, 64'(readdatavalid), 64'd1);
    check(nm, 64'(readdata), 64'(exp));
  endtask

  initial begin
    int pulses;

    reset_n     = 1'b0;
    address     = '0;
    write       = 1'b0;
    read        = 1'b0;
    writedata   = '0;
    byteenable  = '0;
    render_done = 1'b0;

    vecs[0]  = '{1'b0, 16'h0004, 32'h0,        4'h0, 32'h00300000};
    vecs[1]  = '{1'b0, 16'h0000, 32'h0,        4'h0, 32'h00000000};
    vecs[2]  = '{1'b1, 16'h0104, 32'hDEADBEEF, 4'h3, 32'h0000BEEF};
    vecs[3]  = '{1'b1, 16'h0000, 32'hFFFFFFFF, 4'hF, 32'h03FFFFFF};
    vecs[4]  = '{1'b1, 16'h0004, 32'h12345678, 4'h4, 32'h00340000};
    vecs[5]  = '{1'b1, 16'h0800, 32'hCAFEF00D, 4'hF, 32'hCAFEF00D};
    vecs[6]  = '{1'b1, 16'h0808, 32'h11223344, 4'h8, 32'h11000000};
    vecs[7]  = '{1'b1, 16'h080C, 32'hFFFFFFFF, 4'hF, 32'h00000000};
    vecs[8]  = '{1'b1, 16'h0300, 32'hFFFFFFFF, 4'hF, 32'h00000000};
    vecs[9]  = '{1'b1, 16'h023C, 32'hA5A5A5A5, 4'hF, 32'hA5A5A5A5};
    vecs[10] = '{1'b1, 16'h0140, 32'hFFFFFFFF, 4'hF, 32'h00000000};
    vecs[11] = '{1'b0, 16'h0008, 32'h0,        4'h0, 32'h00000000};
    vecs[12] = '{1'b0, 16'h000C, 32'h0,        4'h0, 32'h00000000};
    vecs[13] = '{1'b1, 16'h0008, 32'h00000002, 4'h1, 32'h00000002};

    repeat (2) @(negedge clk);
    check("rst_render_start", 64'(render_start), 64'd0);
    check("rst_irq", 64'(irq), 64'd0);
    check("rst_rdvalid", 64'(readdatavalid), 64'd0);
    check("rst_mat_zero", 64'(mat_out == '0), 64'd1);
    check("rst_vb_active", 64'(vertex_buffer_base), 64'h300000);
    reset_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      if (vecs[i].do_wr) bus_write(vecs[i].addr, vecs[i].wdata, vecs[i].be);
      @(negedge clk);
      address = vecs[i].addr;
      read    = 1'b1;
      @(negedge clk);
      read = 1'b0;
      checks++;
      if (readdatavalid !== 1'b1 || readdata !== vecs[i].exp) begin
        failures++;
        $display("FAIL vec%0d addr=%h got=%h valid=%b exp=%h", i, vecs[i].addr, readdata, readdatavalid, vecs[i].exp);
      end
    end
    @(negedge clk);
    check("rdvalid_single", 64'(readdatavalid), 64'd0);
    check("mat_before_start", 64'(mat_out[63:32]), 64'd0);
    check("light_before_start", 64'(lighting[31:0]), 64'd0);

    // START with IRQ_EN kept set; a lighting write rides the COMMIT cycle
    @(negedge clk);
    address    = 16'h0008;
    writedata  = 32'h3;
    byteenable = 4'h1;
    write      = 1'b1;
    @(negedge clk);
    check("commit_rs_low", 64'(render_start), 64'd0);
    check("commit_mat_old", 64'(mat_out[63:32]), 64'd0);
    address    = 16'h0800;
    writedata  = 32'h0;
    byteenable = 4'hF;
    @(negedge clk);
    write      = 1'b0;
    byteenable = 4'h0;
    check("start_pulse", 64'(render_start), 64'd1);
    check("mat_committed", 64'(mat_out[63:32]), 64'h0000BEEF);
    check("mat_w31", 64'(mat_out[1023:992]), 64'hA5A5A5A5);
    check("light_committed", 64'(lighting[31:0]), 64'hCAFEF00D);
    check("light2_committed", 64'(lighting[95:64]), 64'h11000000);
    check("fb_committed", 64'(frame_buffer_base), 64'h3FFFFFF);
    check("vb_committed", 64'(vertex_buffer_base), 64'h340000);
    @(negedge clk);
    check("start_pulse_end", 64'(render_start), 64'd0);
    bus_read(16'h0800, 32'h0, "commit_cycle_shadow");
    check("commit_cycle_active", 64'(lighting[31:0]), 64'hCAFEF00D);
    bus_read(16'h000C, 32'h1, "status_busy");

    // Second START while busy: overrun, no new pulse
    pulses = 0;
    @(negedge clk);
    address    = 16'h0008;
    writedata  = 32'h3;
    byteenable = 4'h1;
    write      = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      write      = 1'b0;
      byteenable = 4'h0;
      if (render_start) pulses++;
    end
    check("no_second_start", 64'(pulses), 64'd0);
    bus_read(16'h000C, 32'h5, "status_overrun");

    // Completion, then irq one cycle after DONE
    @(negedge clk);
    render_done = 1'b1;
    @(negedge clk);
    render_done = 1'b0;
    check("irq_lag", 64'(irq), 64'd0);
    @(negedge clk);
    check("irq_set", 64'(irq), 64'd1);
    bus_read(16'h000C, 32'h6, "status_done");
    bus_write(16'h000C, 32'h4, 4'h1);
    bus_read(16'h000C, 32'h2, "overrun_cleared");
    bus_write(16'h000C, 32'h2, 4'h1);
    bus_read(16'h000C, 32'h0, "done_cleared");
    check("irq_cleared", 64'(irq), 64'd0);

    // DONE set coinciding with DONE W1C: set wins
    bus_write(16'h0008, 32'h3, 4'h1);
    @(negedge clk);
    address     = 16'h000C;
    writedata   = 32'h2;
    byteenable  = 4'h1;
    write       = 1'b1;
    render_done = 1'b1;
    @(negedge clk);
    write       = 1'b0;
    byteenable  = 4'h0;
    render_done = 1'b0;
    bus_read(16'h000C, 32'h2, "done_set_wins");
    check("irq_after_race", 64'(irq), 64'd1);

    // Reset while busy abandons the render
    bus_write(16'h000C, 32'h2, 4'h1);
    bus_write(16'h0008, 32'h3, 4'h1);
    @(negedge clk);
    bus_read(16'h000C, 32'h1, "busy_before_reset");
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    render_done = 1'b1;
    @(negedge clk);
    render_done = 1'b0;
    bus_read(16'h000C, 32'h0, "status_after_reset");
    bus_read(16'h0008, 32'h0, "ctrl_after_reset");
    bus_read(16'h0004, 32'h00300000, "vb_after_reset");
    bus_read(16'h0104, 32'h0, "mat_shadow_after_reset");
    check("mat_active_after_reset", 64'(mat_out == '0), 64'd1);
    check("light_active_after_reset", 64'(lighting == '0), 64'd1);
    check("irq_after_reset", 64'(irq), 64'd0);
    check("rs_after_reset", 64'(render_start), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
